// File: rtl/dcache_stall_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Stalls the pipeline while a dirty victim is written back and the missing line is refilled.
module dcache_stall_ctrl #(
  parameter int IDX_W  = 4,
  parameter int LINE_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_read_i,
  input  logic              cpu_write_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_rdata_i
);

  localparam int NUM_LINES = 1 << IDX_W;
  localparam int TAG_W     = 32 - IDX_W - 4;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state, next_state;

  logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
  logic [LINE_W-1:0] data_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;

  logic [1:0]       word_sel;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic             req;
  logic             hit;
  logic             ack;
  logic             write_hit;
  logic             refill;
  logic [31:0]      next_addr;
  logic [LINE_W-1:0] next_wdata;
  logic             unused_bits;

  assign word_sel    = cpu_addr_i[3:2];
  assign idx         = cpu_addr_i[IDX_W+3:4];
  assign req_tag     = cpu_addr_i[31:IDX_W+4];
  assign unused_bits = ^cpu_addr_i[1:0];

  assign req       = cpu_read_i | cpu_write_i;
  assign hit       = valid[idx] && (tag_mem[idx] == req_tag);
  assign ack       = mem_ack_i && mem_req_o;
  assign write_hit = (state == IDLE) && cpu_write_i && hit;
  assign refill    = (state == ALLOCATE) && ack;

  assign stall_o     = (state != IDLE) || (req && !hit);
  // A simultaneous read+write is a write, so it never returns load data.
  assign cpu_rdata_o = ((state == IDLE) && cpu_read_i && !cpu_write_i && hit)
                       ? data_mem[idx][{word_sel, 5'b0} +: 32] : 32'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req && !hit)
          next_state = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: if (ack) next_state = ALLOCATE;
      ALLOCATE:  if (ack) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    next_addr  = 32'h0;
    next_wdata = '0;
    case (next_state)
      WRITEBACK: begin
        next_addr  = {tag_mem[idx], idx, 4'b0};
        next_wdata = data_mem[idx];
      end
      ALLOCATE: next_addr = {req_tag, idx, 4'b0};
      default: ;
    endcase
  end

  // Memory-side outputs come from the next state so they hold steady for a whole request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= '0;
    end else begin
      mem_req_o   <= (next_state != IDLE);
      mem_we_o    <= (next_state == WRITEBACK);
      mem_addr_o  <= next_addr;
      mem_wdata_o <= next_wdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (refill) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (write_hit) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Tag and data storage is deliberately left without reset; valid bits guard it.
  always_ff @(posedge clk_i) begin
    if (refill) begin
      data_mem[idx] <= mem_rdata_i;
      tag_mem[idx]  <= req_tag;
    end else if (write_hit) begin
      data_mem[idx][{word_sel, 5'b0} +: 32] <= cpu_wdata_i;
    end
  end

endmodule
